// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared encodings and shadow-slot types for pipeline hazard control
// Revision    : 1.0
// ============================================================================
package mips_pkg;

    localparam int unsigned MIPS_REG_AW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_J    = 2'b10;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic                   valid;
        logic                   reg_write;
        logic [MIPS_REG_AW-1:0] wreg;
        logic                   mem_read;
    } slot_t;

    typedef struct packed {
        slot_t                  w;
        logic [MIPS_REG_AW-1:0] rs;
        logic [MIPS_REG_AW-1:0] rt;
        logic                   use_rs;
        logic                   use_rt;
    } ex_slot_t;

    // A slot only counts as producing r when it really writes a non-zero register;
    // allow_load=0 additionally rejects a load whose data is not yet available.
    function automatic logic slot_hit(input slot_t s, input logic [MIPS_REG_AW-1:0] r,
                                      input logic allow_load);
        return s.valid && s.reg_write && (s.wreg == r) && (r != '0) &&
               (allow_load || !s.mem_read);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_slot.sv
`default_nettype none
// ============================================================================
// Module      : hazard_slot
// Description : Shadow-slot register with load and bubble (clear) control
// Revision    : 1.0
// ============================================================================
module hazard_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] slot_q;
    logic [W-1:0] slot_d;

    // An all-zero slot is an invalid bubble.
    always_comb begin
        slot_d = slot_q;
        if (bubble_i) begin
            slot_d = '0;
        end else if (load_i) begin
            slot_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall, flush, forwarding and next-PC control for a 5-stage MIPS pipe
// Revision    : 1.0
// ============================================================================
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned REG_AW = MIPS_REG_AW,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_wreg,
    input  logic              id_mem_read,
    input  logic              id_jump,
    input  logic              mem_br_taken,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        pc_sel,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              id_byp_a,
    output logic              id_byp_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ex_slot_t  ex_d, ex_q;
    slot_t     mem_q, wb_q;
    hz_state_t state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic br, jmp, lu, stall, flush_ev;

    // Gating with rst keeps every control output at its idle value while in reset.
    assign br  = mem_br_taken & rst;
    assign jmp = id_jump & rst;
    assign lu  = ex_q.w.mem_read &
                 ((id_use_rs & slot_hit(ex_q.w, id_rs, 1'b1)) |
                  (id_use_rt & slot_hit(ex_q.w, id_rt, 1'b1)));
    assign stall    = lu & ~br;
    assign flush_ev = br | (jmp & ~stall);

    always_comb begin
        ex_d             = '0;
        ex_d.w.valid     = 1'b1;
        ex_d.w.reg_write = id_reg_write;
        ex_d.w.wreg      = id_wreg;
        ex_d.w.mem_read  = id_mem_read;
        ex_d.rs          = id_rs;
        ex_d.rt          = id_rt;
        ex_d.use_rs      = id_use_rs;
        ex_d.use_rt      = id_use_rt;
    end

    hazard_slot #(.W($bits(ex_slot_t))) u_ex_slot (
        .clk(clk), .rst(rst), .load_i(1'b1), .bubble_i(br | stall), .d_i(ex_d), .q_o(ex_q)
    );
    hazard_slot #(.W($bits(slot_t))) u_mem_slot (
        .clk(clk), .rst(rst), .load_i(1'b1), .bubble_i(br), .d_i(ex_q.w), .q_o(mem_q)
    );
    hazard_slot #(.W($bits(slot_t))) u_wb_slot (
        .clk(clk), .rst(rst), .load_i(1'b1), .bubble_i(1'b0), .d_i(mem_q), .q_o(wb_q)
    );

    always_comb begin
        state_d = RUN;
        if (state_q == RUN && stall) begin
            state_d = LU_STALL;
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_sel       = PC_SEQ;
        if (br) begin
            pc_sel       = PC_BR;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (jmp) begin
            pc_sel      = PC_J;
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        fwd_a = FWD_REG;
        if (ex_q.use_rs && slot_hit(mem_q, ex_q.rs, 1'b0)) begin
            fwd_a = FWD_MEM;
        end else if (slot_hit(wb_q, ex_q.rs, 1'b1)) begin
            fwd_a = FWD_WB;
        end
        fwd_b = FWD_REG;
        if (ex_q.use_rt && slot_hit(mem_q, ex_q.rt, 1'b0)) begin
            fwd_b = FWD_MEM;
        end else if (slot_hit(wb_q, ex_q.rt, 1'b1)) begin
            fwd_b = FWD_WB;
        end
    end

    assign id_byp_a = id_use_rs & slot_hit(wb_q, id_rs, 1'b1);
    assign id_byp_b = id_use_rt & slot_hit(wb_q, id_rt, 1'b1);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_ev && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Directed, table-driven bench for pipe_hazard_ctrl; a 4-bit-counter copy
// shares the stimulus so counter saturation is reachable in few cycles.
module tb_pipe_hazard_ctrl;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_wreg;
    logic       id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_jump, mem_br_taken;

    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, id_byp_a, id_byp_b;
    logic [1:0]  pc_sel, fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_byp_a, s_byp_b;
    logic [1:0]  s_pc_sel, s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_reg_write(id_reg_write), .id_wreg(id_wreg),
        .id_mem_read(id_mem_read), .id_jump(id_jump), .mem_br_taken(mem_br_taken),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .pc_sel(pc_sel),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_reg_write(id_reg_write), .id_wreg(id_wreg),
        .id_mem_read(id_mem_read), .id_jump(id_jump), .mem_br_taken(mem_br_taken),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
        .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush), .pc_sel(s_pc_sel),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .id_byp_a(s_byp_a), .id_byp_b(s_byp_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       rw;
        logic [4:0] wreg;
        logic       mr;
        logic       jump;
        logic       br;
    } in_t;

    typedef struct packed {
        logic        pc_en;
        logic        if_id_en;
        logic        if_id_flush;
        logic        id_ex_flush;
        logic        ex_mem_flush;
        logic [1:0]  pc_sel;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic        byp_a;
        logic        byp_b;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic in_t ins(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic rw, input logic [4:0] wreg,
                                input logic mr, input logic j, input logic b);
        return {rs, rt, urs, urt, rw, wreg, mr, j, b};
    endfunction

    function automatic out_t o_run(input logic [1:0] fa, input logic [1:0] fb, input logic ba,
                                   input logic bb, input logic [15:0] sc, input logic [15:0] fc);
        return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PC_SEQ, fa, fb, ba, bb, sc, fc};
    endfunction

    function automatic out_t o_stall(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [15:0] sc, input logic [15:0] fc);
        return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, PC_SEQ, fa, fb, 1'b0, 1'b0, sc, fc};
    endfunction

    function automatic out_t o_br(input logic [1:0] fa, input logic [1:0] fb,
                                  input logic [15:0] sc, input logic [15:0] fc);
        return {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, PC_BR, fa, fb, 1'b0, 1'b0, sc, fc};
    endfunction

    function automatic out_t o_j(input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [15:0] sc, input logic [15:0] fc);
        return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, PC_J, fa, fb, 1'b0, 1'b0, sc, fc};
    endfunction

    function automatic out_t actual();
        return {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, pc_sel,
                fwd_a, fwd_b, id_byp_a, id_byp_b, stall_cnt, flush_cnt};
    endfunction

    task automatic drive(input in_t v);
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_use_rs    = v.use_rs;
        id_use_rt    = v.use_rt;
        id_reg_write = v.rw;
        id_wreg      = v.wreg;
        id_mem_read  = v.mr;
        id_jump      = v.jump;
        mem_br_taken = v.br;
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act = actual();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    in_t nop, lw2, add3;

    initial begin
        nop  = ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw2  = ins(1, 2, 1, 0, 1, 2, 1, 0, 0);
        add3 = ins(2, 4, 1, 1, 1, 3, 0, 0, 0);

        vecs.push_back('{i: lw2,                                 o: o_run(FWD_REG, FWD_REG, 0, 0, 0, 0)});
        vecs.push_back('{i: add3,                                o: o_stall(FWD_REG, FWD_REG, 0, 0)});
        vecs.push_back('{i: add3,                                o: o_run(FWD_REG, FWD_REG, 0, 0, 1, 0)});
        vecs.push_back('{i: ins(1, 1, 1, 1, 1, 2, 0, 0, 0),      o: o_run(FWD_WB,  FWD_REG, 0, 0, 1, 0)});
        vecs.push_back('{i: ins(2, 2, 1, 1, 1, 5, 0, 0, 0),      o: o_run(FWD_REG, FWD_REG, 0, 0, 1, 0)});
        vecs.push_back('{i: ins(7, 7, 1, 1, 1, 2, 0, 0, 0),      o: o_run(FWD_MEM, FWD_MEM, 0, 0, 1, 0)});
        vecs.push_back('{i: ins(2, 0, 1, 1, 1, 6, 0, 0, 0),      o: o_run(FWD_REG, FWD_REG, 1, 0, 1, 0)});
        vecs.push_back('{i: ins(1, 1, 1, 1, 1, 0, 0, 0, 0),      o: o_run(FWD_MEM, FWD_REG, 0, 0, 1, 0)});
        vecs.push_back('{i: ins(0, 0, 1, 1, 1, 9, 0, 0, 0),      o: o_run(FWD_REG, FWD_REG, 0, 0, 1, 0)});
        vecs.push_back('{i: nop,                                 o: o_run(FWD_REG, FWD_REG, 0, 0, 1, 0)});
        vecs.push_back('{i: ins(0, 10, 1, 0, 1, 10, 1, 0, 0),    o: o_run(FWD_REG, FWD_REG, 0, 0, 1, 0)});
        vecs.push_back('{i: ins(10, 0, 1, 0, 0, 0, 0, 1, 1),     o: o_br(FWD_REG, FWD_REG, 1, 0)});
        vecs.push_back('{i: ins(0, 0, 0, 0, 0, 0, 0, 1, 0),      o: o_j(FWD_REG, FWD_REG, 1, 1)});
        vecs.push_back('{i: ins(0, 0, 1, 0, 1, 7, 0, 0, 0),      o: o_run(FWD_REG, FWD_REG, 0, 0, 1, 2)});
        vecs.push_back('{i: nop,                                 o: o_run(FWD_REG, FWD_REG, 0, 0, 1, 2)});
        vecs.push_back('{i: nop,                                 o: o_run(FWD_REG, FWD_REG, 0, 0, 1, 2)});
        vecs.push_back('{i: ins(7, 7, 1, 0, 0, 0, 0, 0, 0),      o: o_run(FWD_REG, FWD_REG, 1, 0, 1, 2)});
        vecs.push_back('{i: lw2,                                 o: o_run(FWD_REG, FWD_REG, 0, 0, 1, 2)});

        // Reset values, including with branch and jump asserted.
        rst = 1'b0;
        drive(nop);
        #1;
        check_out("reset_idle", o_run(FWD_REG, FWD_REG, 0, 0, 0, 0));
        drive(ins(3, 3, 1, 1, 1, 3, 1, 1, 1));
        #1;
        check_out("reset_br_jump", o_run(FWD_REG, FWD_REG, 0, 0, 0, 0));
        drive(nop);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].i);
            #1;
            check_out($sformatf("vec%0d", k), vecs[k].o);
        end

        // Load-use with a jump in ID: stall wins, then reset lands inside LU_STALL.
        @(negedge clk);
        drive(ins(2, 4, 1, 1, 1, 3, 0, 1, 0));
        #1;
        check_out("lu_over_jump", o_stall(FWD_REG, FWD_REG, 1, 2));
        @(negedge clk);
        #1;
        check_out("jump_after_stall", o_j(FWD_REG, FWD_REG, 2, 2));
        drive(ins(2, 4, 1, 1, 1, 3, 0, 1, 1));
        rst = 1'b0;
        #1;
        check_out("async_reset_mid_stall", o_run(FWD_REG, FWD_REG, 0, 0, 0, 0));
        @(negedge clk);
        drive(nop);
        rst = 1'b1;

        // 21 load-use stalls, then 18 jumps: the 4-bit copy must pin at 15.
        for (int n = 0; n < 21; n++) begin
            @(negedge clk);
            drive(lw2);
            @(negedge clk);
            drive(add3);
        end
        @(negedge clk);
        drive(nop);
        #1;
        check_val("stall_cnt_16b", int'(stall_cnt), 21);
        check_val("stall_cnt_sat", int'(s_stall_cnt), 15);
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            drive(ins(0, 0, 0, 0, 0, 0, 0, 1, 0));
        end
        @(negedge clk);
        drive(nop);
        #1;
        check_val("flush_cnt_16b", int'(flush_cnt), 18);
        check_val("flush_cnt_sat", int'(s_flush_cnt), 15);
        check_val("stall_cnt_hold", int'(s_stall_cnt), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It tracks the destination register, write-enable and load flag of every instruction in flight, and from these generates four kinds of control:
- load-use stalls;
- EX-stage operand forwarding selects plus a WB→ID register-file bypass;
- flushes for jumps resolved in ID and branches resolved in MEM;
- the next-PC select.

It sits beside the pipeline registers, drives their enable/flush inputs, and keeps saturating stall/flush event counters for debug.

## Interface
Parameters:
- `REG_AW`, 5: register-address width.
- `CNT_W`, 16: width of each event counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `id_rs`, `id_rt`  in  REG_AW  source registers of the instruction in ID.
- `id_use_rs`, `id_use_rt`  in  1  ID instruction actually reads rs / rt.
- `id_reg_write`  in  1  ID instruction writes the register file.
- `id_wreg`  in  REG_AW  ID destination register, already RegDst-resolved.
- `id_mem_read`  in  1  ID instruction is a load.
- `id_jump`  in  1  ID instruction is a jump.
- `mem_br_taken`  in  1  the branch in MEM is taken (Branch & zero).
- `pc_en`, `if_id_en`  out  1  write enables for PC and IF/ID.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1  load a bubble into that pipeline register.
- `pc_sel`  out  2  next-PC select.
- `fwd_a`, `fwd_b`  out  2  EX operand A/B source.
- `id_byp_a`, `id_byp_b`  out  1  replace rdata1/rdata2 in ID with the WB write data.
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating event counters.

## Operation
**Shadow slots.** Three slots, EX, MEM and WB. Each holds {valid, reg_write, wreg, mem_read}; the EX slot additionally holds {rs, rt, use_rs, use_rt}.

**Write-hazard qualifier.** A slot "writes r" only when valid & reg_write & wreg==r & r!=0. Register 0 never causes a hazard, a forward or a bypass.

**Load-use detect.** `lu` = EX slot valid & mem_read & writes r, where r = id_rs with id_use_rs, or r = id_rt with id_use_rt.

**FSM states** (`RUN`, `LU_STALL`):
- `RUN` → `LU_STALL` when `lu` & !mem_br_taken.
- `LU_STALL` → `RUN` unconditionally after one cycle.
- In `LU_STALL` the load is in MEM, so `lu` cannot re-fire for the same pair. A new `lu` raised on the return to `RUN` is evaluated normally.

**Stall** (`lu` & !mem_br_taken):
- Outputs: pc_en=0, if_id_en=0, id_ex_flush=1.
- Slots: EX←bubble, MEM←EX, WB←MEM.

**Taken branch** (mem_br_taken). Highest priority; overrides stall and jump.
- Outputs: pc_sel=PC_BR, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, pc_en=1.
- Slots: EX←bubble, MEM←bubble, WB←MEM.

**Jump** (id_jump, no taken branch, no stall).
- Outputs: pc_sel=PC_J, if_id_flush=1.
- The jump itself advances into EX.

**Normal.** pc_sel=PC_SEQ, all enables 1, no flushes. Slots shift: EX←ID inputs (valid=1), MEM←EX, WB←MEM.

**Forwarding** (A shown; B is identical using rt/use_rt):
- fwd_a=FWD_MEM if the MEM slot writes EX.rs & EX.use_rs and is not a load;
- else FWD_WB if the WB slot writes EX.rs;
- else FWD_REG.
- MEM wins over WB. A load in MEM never forwards from MEM; this case cannot occur because of the stall.

**ID bypass.** id_byp_a = WB slot writes id_rs & id_use_rs. Same for B with rt. This covers the same-edge register-file write/read.

**Counters.**
- stall_cnt +1 per stall cycle; flush_cnt +1 per taken branch or jump.
- Both saturate at all-ones and do not wrap.

## Timing
- All control outputs are combinational from slot state and same-cycle ID/MEM inputs. There is zero-cycle latency to the pipeline-register enables.
- Slots, FSM state and counters update on the rising clk edge.
- Load-use costs exactly 1 bubble. A taken branch costs 3 bubbles. A jump costs 1 bubble.
- Reset (rst=0, asynchronous, any time including mid-stall or mid-flush):
  - all slots invalid, FSM=RUN, counters=0;
  - outputs: pc_en=1, if_id_en=1, all flushes 0, pc_sel=PC_SEQ, fwd=FWD_REG, bypass=0.
- Reset release is synchronous to clk.

## Structure
- Shared package `mips_pkg`:
  - `FWD_REG`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - `PC_SEQ`=2'b00, `PC_BR`=2'b01, `PC_J`=2'b10;
  - FSM state enum;
  - the slot struct type.
- One sub-module, `hazard_slot`: a parameterised shadow-slot register with load, bubble and async active-low reset. It is instantiated three times.

## Test plan
- `lw $2,0($1)` followed by `add $3,$2,$4` → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1 and stall_cnt=1; on the next cycle fwd_a=FWD_WB for $2.
- `add $2,..` followed by `sub $5,$2,$2` → no stall; fwd_a=fwd_b=FWD_MEM while sub is in EX.
- `add $2`, `add $2`, `or $6,$2,$0` → fwd_a=FWD_MEM (the younger add); fwd_b=FWD_REG. Writes to $0 never forward.
- mem_br_taken=1 coincident with `lu`=1 and id_jump=1 → pc_sel=PC_BR, all three flushes=1, pc_en=1, no stall; flush_cnt +1.
- Jump in ID → pc_sel=PC_J, if_id_flush=1 for one cycle. A WB write to $7 while ID reads $7 → id_byp_a=1.
- Drive rst=0 during LU_STALL → outputs return to their reset values immediately (asynchronously). Force 2^16+5 stalls → stall_cnt holds at 16'hFFFF.
